bus_ram: RTL
============

// Module: bus_ram
// PURPOSE
//  Byte-addressable RAM slave (responder) on the shared system bus; services masters (CPU, DMA).
//  Decodes its address window, inserts programmable wait states, answers via fc_bus handshake.
//  Drives data_bus only for its own reads; fc_bus only while addressed; otherwise high-Z.
// PARAMETERS
//  BASE_ADDR    32'h1000_0000  window base; aligned to 2^(ADDR_WIDTH+2) bytes
//  ADDR_WIDTH   10             word-address bits; memory = 2^ADDR_WIDTH x 32-bit words
//  WAIT_STATES  2              extra cycles between request sample and ack (0..15)
// PORTS
//  clk            in     1   clock
//  rst            in     1   reset, asynchronous, active-high
//  addr_bus       in     32  byte address from current master
//  data_bus       inout  32  write data in / read data out (driven only in read ACK)
//  rd_bus         in     1   read strobe
//  wr_bus         in     1   write strobe
//  data_mask_bus  in     4   byte-lane enables, lane i = data_bus[8i+7:8i]
//  fc_bus         inout  1   function complete; driven only while hit && (rd^wr), else Z
// BEHAVIOUR
//  - hit = addr_bus[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]; valid = rd_bus ^ wr_bus;
//    req = hit && valid. rd&&wr both high: invalid, ignored, fc Z.
//  - word = addr_bus[ADDR_WIDTH+1:2], off = addr_bus[1:0]; {addr,rd,wr,mask,wdata} latched at accept.
//  - FSM: IDLE, WAIT, ACK, HOLD. Reset -> IDLE, wait counter 0; memory contents NOT reset.
//  - IDLE: req at edge -> latch; WAIT_STATES==0 ? ACK : WAIT with cnt=WAIT_STATES-1.
//  - WAIT: req dropped or addr/rd/wr changed -> IDLE (abort, no write); cnt==0 -> ACK; else cnt--.
//  - Entry to ACK (same edge): write commits latched lanes; read captures rdata.
//  - ACK: fc_bus=1 for exactly one cycle; next state HOLD. Ack latency = WAIT_STATES+1 cycles
//    after accept edge.
//  - HOLD: fc_bus=0 (driven while req). Leave to IDLE when req drops OR addr/rd/wr differ from
//    latched; a different new request in that cycle is evaluated by IDLE on the next edge.
//    Unchanged held request never re-executes.
//  - Read data: rdata = mem[word] >> (8*off), zero-filled top; data_bus = rdata only in ACK of read.
//  - Write: lane i (mask[i]) -> byte off+i of mem[word]; lanes with off+i>3 dropped (no spill to
//    next word); mask 4'b0000 completes handshake with no change.
//  - fc_bus in IDLE/WAIT while req: 0. Outputs during reset: data_bus Z, fc_bus Z.
//  - Reset mid-op: FSM -> IDLE at once, pending write discarded, written words kept.
// TESTING
//  1 WAIT_STATES=2: write 32'hDEADBEEF mask 4'hF @BASE+8, hold -> fc 1 cycle, 3 clk after accept;
//    read back -> data_bus 32'hDEADBEEF with fc.
//  2 Unaligned: word@BASE+0=32'h44332211, write 8'hAA mask 4'h1 @BASE+2 -> word 32'h44AA2211;
//    read @BASE+1 -> 32'h0044AA22.
//  3 Spill: write 32'h0000BBCC mask 4'h3 @BASE+3 -> only byte3=8'hCC; BASE+4 word unchanged.
//  4 DMA-style back-to-back: read @BASE+0, addr->BASE+4 + wr right after fc -> one ack each;
//    held unchanged read -> single fc pulse.
//  5 Abort/illegal: drop rd in WAIT -> no fc, IDLE; rd=wr=1 or addr outside window -> fc and data Z.
//  6 rst during WAIT of a write -> no write, IDLE, fc Z; prior contents intact on read.

Source files
------------

// File: rtl/bus_ram.sv
// Byte-addressable RAM responder on the shared system bus. It decodes its own address window,
// inserts WAIT_STATES wait cycles and completes each access with a one-cycle fc_bus pulse.
module bus_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_bus,
    inout  wire  [31:0] data_bus,
    input  logic        rd_bus,
    input  logic        wr_bus,
    input  logic [3:0]  data_mask_bus,
    inout  wire         fc_bus
);

    localparam int          DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [31:0]            addr_reg;
    logic                   rd_reg;
    logic                   wr_reg;
    logic [3:0]             mask_reg;
    logic [31:0]            wdata_reg;

    logic                   hit;
    logic                   req;
    logic                   same;
    logic                   accept;
    logic                   go_ack;

    logic                   from_bus;
    logic [ADDR_WIDTH-1:0]  sel_word;
    logic [1:0]             sel_off;
    logic                   sel_rd;
    logic                   sel_wr;
    logic [3:0]             sel_mask;
    logic [31:0]            sel_wdata;
    logic [3:0]             lane_en;
    logic [31:0]            lane_data;
    logic                   mem_we;
    logic                   mem_re;
    logic [31:0]            rraw;
    logic [31:0]            rdata;

    assign hit    = (addr_bus[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign req    = hit && (rd_bus ^ wr_bus);
    assign same   = (addr_bus == addr_reg) && (rd_bus == rd_reg) && (wr_bus == wr_reg);
    assign accept = (state_reg == IDLE) && req;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        go_ack     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ACK;
                        go_ack     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // A master that gives up or retargets mid-wait cancels the access entirely.
                if (!req || !same) begin
                    state_next = IDLE;
                end else if (cnt_reg == 4'd0) begin
                    state_next = ACK;
                    go_ack     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACK: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (!req || !same) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            mask_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg  <= addr_bus;
                rd_reg    <= rd_bus;
                wr_reg    <= wr_bus;
                mask_reg  <= data_mask_bus;
                wdata_reg <= data_bus;
            end
        end
    end

    // With zero wait states the access commits on the accept edge, before the latch is loaded.
    assign from_bus  = (state_reg == IDLE);
    assign sel_word  = from_bus ? addr_bus[ADDR_WIDTH+1:2] : addr_reg[ADDR_WIDTH+1:2];
    assign sel_off   = from_bus ? addr_bus[1:0]            : addr_reg[1:0];
    assign sel_rd    = from_bus ? rd_bus                   : rd_reg;
    assign sel_wr    = from_bus ? wr_bus                   : wr_reg;
    assign sel_mask  = from_bus ? data_mask_bus            : mask_reg;
    assign sel_wdata = from_bus ? data_bus                 : wdata_reg;

    // Shifting in a 4-bit / 32-bit context drops lanes that would spill past byte 3.
    assign lane_en   = sel_mask << sel_off;
    assign lane_data = sel_wdata << {sel_off, 3'b000};

    assign mem_we = go_ack && sel_wr && !rst;
    assign mem_re = go_ack && sel_rd && !rst;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [0:DEPTH-1];
        logic [7:0] rbyte;

        always_ff @(posedge clk) begin
            if (mem_we && lane_en[gi]) begin
                mem[sel_word] <= lane_data[8*gi +: 8];
            end
            if (mem_re) begin
                rbyte <= mem[sel_word];
            end
        end

        assign rraw[8*gi +: 8] = rbyte;
    end

    assign rdata = rraw >> {addr_reg[1:0], 3'b000};

    assign data_bus = (!rst && (state_reg == ACK) && rd_reg) ? rdata : 32'bz;
    assign fc_bus   = (!rst && req) ? (state_reg == ACK) : 1'bz;

endmodule
